sdram_arbiter: RTL and testbench

- Shares the single 8-bit SDRAM port between three requesters:
  - ROM/image download writes from hps_io (ioctl).
  - Renderer image-fetch reads.
  - An auxiliary read channel for palette/config readback and future save-state access.
- Replaces the ad-hoc address mux in the top level.
- Sequences one SDRAM command at a time, applies ioctl backpressure, adds the image base address and returns read data with an acknowledge pulse.

---
 rtl/sdram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shares the single SDRAM port between ioctl download writes, renderer image reads and an aux read channel.
// One command in flight at a time; read data returns with a one-cycle ack on the granted channel.
module sdram_arbiter #(
  parameter int AW      = 25,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [DW-1:0] ioctl_dout,
  output logic          ioctl_wait,
  input  logic [AW-1:0] img_base,
  input  logic          img_req,
  input  logic [AW-1:0] img_offs,
  output logic          img_ack,
  output logic [DW-1:0] img_data,
  input  logic          aux_req,
  input  logic [AW-1:0] aux_addr,
  output logic          aux_ack,
  output logic [DW-1:0] aux_data,
  output logic [AW-1:0] sdram_addr,
  output logic [DW-1:0] sdram_din,
  output logic          sdram_rd,
  output logic          sdram_we,
  input  logic [DW-1:0] sdram_dout,
  input  logic          sdram_ready,
  output logic          err_timeout,
  output logic          err_overflow
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_MASK, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {G_WR, G_IMG, G_AUX} gnt_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t        state, state_nxt;
  gnt_t          gnt, gnt_nxt;
  logic          grant, wait_done, wait_to;
  logic          pend, pend_nxt, cap, drop;
  logic          rr_ptr;
  logic [15:0]   cnt;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] img_sum, addr_sel;

  // Image address wraps modulo 2^AW by truncation.
  assign img_sum = img_base + img_offs;
  assign cap     = ioctl_download & ioctl_wr & ~pend;
  assign drop    = ioctl_download & ioctl_wr & pend;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    grant     = 1'b0;
    wait_done = 1'b0;
    wait_to   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend) begin
          grant   = 1'b1;
          gnt_nxt = G_WR;
        end else if (!ioctl_download) begin
          if (img_req && aux_req) begin
            grant   = 1'b1;
            gnt_nxt = rr_ptr ? G_AUX : G_IMG;
          end else if (img_req) begin
            grant   = 1'b1;
            gnt_nxt = G_IMG;
          end else if (aux_req) begin
            grant   = 1'b1;
            gnt_nxt = G_AUX;
          end
        end
        if (grant) state_nxt = S_CMD;
      end
      S_CMD:  state_nxt = S_MASK;
      S_MASK: state_nxt = S_WAIT;
      S_WAIT: begin
        if (sdram_ready) begin
          wait_done = 1'b1;
          state_nxt = S_RESP;
        end else if (cnt == CNT_LAST) begin
          wait_to   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    pend_nxt = pend;
    if (cap) pend_nxt = 1'b1;
    else if (state == S_RESP && gnt == G_WR) pend_nxt = 1'b0;

    case (gnt_nxt)
      G_WR:    addr_sel = wr_addr;
      G_IMG:   addr_sel = img_sum;
      default: addr_sel = aux_addr;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= S_IDLE;
      gnt   <= G_WR;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Write holding register and watchdog counter carry no reset.
  always_ff @(posedge clk_sys) begin
    if (cap) begin
      wr_addr <= ioctl_addr;
      wr_data <= ioctl_dout;
    end
    if (state == S_MASK) cnt <= '0;
    else if (state == S_WAIT) cnt <= cnt + 16'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend         <= 1'b0;
      rr_ptr       <= 1'b0;
      ioctl_wait   <= 1'b0;
      img_ack      <= 1'b0;
      aux_ack      <= 1'b0;
      sdram_rd     <= 1'b0;
      sdram_we     <= 1'b0;
      img_data     <= '0;
      aux_data     <= '0;
      sdram_addr   <= '0;
      sdram_din    <= '0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      pend       <= pend_nxt;
      ioctl_wait <= pend_nxt | ((state_nxt != S_IDLE) & ioctl_download);
      sdram_rd   <= grant && (gnt_nxt != G_WR);
      sdram_we   <= grant && (gnt_nxt == G_WR);
      if (grant) begin
        sdram_addr <= addr_sel;
        if (gnt_nxt == G_WR) sdram_din <= wr_data;
        // Point at the side that did not just win.
        if (gnt_nxt == G_IMG) rr_ptr <= 1'b1;
        else if (gnt_nxt == G_AUX) rr_ptr <= 1'b0;
      end
      img_ack <= (wait_done | wait_to) && (gnt == G_IMG);
      aux_ack <= (wait_done | wait_to) && (gnt == G_AUX);
      if ((wait_done | wait_to) && gnt == G_IMG) img_data <= wait_done ? sdram_dout : '0;
      if ((wait_done | wait_to) && gnt == G_AUX) aux_data <= wait_done ? sdram_dout : '0;
      if (wait_to) err_timeout  <= 1'b1;
      if (drop)    err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected commands and acks are queued as stimulus is driven
// and popped when the arbiter issues them; a small SDRAM model answers reads.
module tb_sdram_arbiter;
  localparam int AW = 25;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [DW-1:0] ioctl_dout = '0;
  logic          ioctl_wait;
  logic [AW-1:0] img_base = '0, img_offs = '0, aux_addr = '0;
  logic          img_req = 1'b0, aux_req = 1'b0;
  logic          img_ack, aux_ack;
  logic [DW-1:0] img_data, aux_data;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_din;
  logic          sdram_rd, sdram_we;
  logic [DW-1:0] sdram_dout = '0;
  logic          sdram_ready;
  logic          err_timeout, err_overflow;

  logic ready_m = 1'b1, hold_low = 1'b0;
  int   rdy_delay = 0, rdy_cnt = 0;
  assign sdram_ready = ready_m & ~hold_low;

  sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .img_base(img_base), .img_req(img_req), .img_offs(img_offs), .img_ack(img_ack), .img_data(img_data),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_ack(aux_ack), .aux_data(aux_data),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_dout(sdram_dout), .sdram_ready(sdram_ready),
    .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] din; } cmd_t;
  typedef struct { logic aux; logic [DW-1:0] data; int lat; } ack_t;
  cmd_t cmd_q[$];
  ack_t ack_q[$];

  int n_checks = 0, n_err = 0;
  int cyc = 0, last_cmd_cyc = 0, we_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clk_sys) cyc++;

  // SDRAM model and output monitor.
  always @(negedge clk_sys) begin
    cmd_t c;
    ack_t a;
    if (sdram_rd || sdram_we) begin
      last_cmd_cyc = cyc;
      if (sdram_we) we_cnt++;
      if (sdram_rd) sdram_dout = mem_val(sdram_addr);
      if (rdy_delay > 0) begin
        ready_m = 1'b0;
        rdy_cnt = rdy_delay;
      end
      check_val("cmd_excl", {31'd0, sdram_rd & sdram_we}, 32'd0);
      if (cmd_q.size() == 0) check_val("cmd_unexp", 32'd1, 32'd0);
      else begin
        c = cmd_q.pop_front();
        check_val("cmd_we", {31'd0, sdram_we}, {31'd0, c.we});
        check_val("cmd_addr", 32'(sdram_addr), 32'(c.addr));
        if (c.we) check_val("cmd_din", 32'(sdram_din), 32'(c.din));
      end
    end else if (rdy_cnt > 0) begin
      rdy_cnt--;
      if (rdy_cnt == 0) ready_m = 1'b1;
    end
    if (img_ack || aux_ack) begin
      check_val("ack_excl", {31'd0, img_ack & aux_ack}, 32'd0);
      if (ack_q.size() == 0) check_val("ack_unexp", 32'd1, 32'd0);
      else begin
        a = ack_q.pop_front();
        check_val("ack_chan", {31'd0, aux_ack}, {31'd0, a.aux});
        check_val("ack_data", 32'(a.aux ? aux_data : img_data), 32'(a.data));
        check_val("ack_lat", 32'(cyc - last_cmd_cyc), 32'(a.lat));
      end
    end
  end

  task automatic push_rd(input logic aux, input logic [AW-1:0] addr, input int lat, input logic tmo);
    cmd_t c;
    ack_t a;
    c.we = 1'b0; c.addr = addr; c.din = '0;
    cmd_q.push_back(c);
    a.aux = aux; a.data = tmo ? 8'h00 : mem_val(addr); a.lat = lat;
    ack_q.push_back(a);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (ioctl_wait && k < 60) begin
      @(negedge clk_sys);
      k++;
    end
    if (k >= 60) check_val(tag, 32'd1, 32'd0);
  endtask

  task automatic wait_acks(input int n, input string tag);
    int got, k;
    got = 0;
    for (k = 0; k < 80 && got < n; k++) begin
      @(negedge clk_sys);
      if (img_ack || aux_ack) got++;
    end
    if (got < n) check_val(tag, 32'(got), 32'(n));
    img_req = 1'b0;
    aux_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"}, {21'd0, ioctl_wait, img_ack, aux_ack, sdram_rd, sdram_we,
                               err_timeout, err_overflow, 5'd0}, 32'd0);
    check_val({tag, "_data"}, {16'd0, img_data, aux_data}, 32'd0);
    check_val({tag, "_addr"}, 32'(sdram_addr), 32'd0);
    check_val({tag, "_din"}, 32'(sdram_din), 32'd0);
  endtask

  initial begin
    cmd_t c;
    int k, we0;
    repeat (3) @(negedge clk_sys);
    check_all_zero("rst");
    reset = 1'b0;

    // Download: four writes, ready two cycles after each command.
    rdy_delay = 2;
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      wait_idle("dl_tmo");
      ioctl_wr = 1'b1;
      ioctl_addr = AW'(32'h10 + i);
      ioctl_dout = 8'hA0 + 8'(i);
      c.we = 1'b1; c.addr = ioctl_addr; c.din = ioctl_dout;
      cmd_q.push_back(c);
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      check_val("dl_wait", {31'd0, ioctl_wait}, 32'd1);
    end
    wait_idle("dl_tmo");
    repeat (2) @(negedge clk_sys);
    check_val("dl_we_cnt", 32'(we_cnt), 32'd4);
    check_val("dl_ovf", {31'd0, err_overflow}, 32'd0);

    // Overflow: second strobe arrives while the first is still pending.
    rdy_delay = 6;
    we0 = we_cnt;
    ioctl_wr = 1'b1; ioctl_addr = 25'h55; ioctl_dout = 8'h77;
    c.we = 1'b1; c.addr = 25'h55; c.din = 8'h77;
    cmd_q.push_back(c);
    @(negedge clk_sys); ioctl_wr = 1'b0;
    @(negedge clk_sys); ioctl_wr = 1'b1; ioctl_addr = 25'h66; ioctl_dout = 8'h88;
    @(negedge clk_sys); ioctl_wr = 1'b0;
    check_val("ovf_flag", {31'd0, err_overflow}, 32'd1);
    wait_idle("ovf_tmo");
    repeat (8) @(negedge clk_sys);
    check_val("ovf_we_cnt", 32'(we_cnt - we0), 32'd1);
    ioctl_download = 1'b0;
    rdy_delay = 0;
    @(negedge clk_sys);

    // Round-robin with both requesters held.
    img_base = 25'h100000; img_offs = 25'd5; aux_addr = 25'h20;
    for (int i = 0; i < 2; i++) begin
      push_rd(1'b0, 25'h100005, 3, 1'b0);
      push_rd(1'b1, 25'h000020, 3, 1'b0);
    end
    img_req = 1'b1; aux_req = 1'b1;
    wait_acks(4, "rr_tmo");
    repeat (6) @(negedge clk_sys);

    // Address wrap.
    img_base = 25'h1FFFFFF; img_offs = 25'd2;
    push_rd(1'b0, 25'h0000001, 3, 1'b0);
    img_req = 1'b1;
    wait_acks(1, "wrap_tmo");
    repeat (3) @(negedge clk_sys);

    // Watchdog timeout.
    hold_low = 1'b1;
    img_base = 25'h0; img_offs = 25'h33;
    push_rd(1'b0, 25'h33, 10, 1'b1);
    img_req = 1'b1;
    wait_acks(1, "to_tmo");
    check_val("to_flag", {31'd0, err_timeout}, 32'd1);
    repeat (3) @(negedge clk_sys);

    // Reset during WAIT of an aux read.
    aux_addr = 25'h44;
    c.we = 1'b0; c.addr = 25'h44; c.din = '0;
    cmd_q.push_back(c);
    aux_req = 1'b1;
    k = 0;
    while (!sdram_rd && k < 20) begin
      @(negedge clk_sys);
      k++;
    end
    if (k >= 20) check_val("rst_cmd_tmo", 32'd1, 32'd0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b1; aux_req = 1'b0;
    @(negedge clk_sys);
    check_all_zero("midrst");
    reset = 1'b0; hold_low = 1'b0;
    repeat (2) @(negedge clk_sys);
    img_base = 25'h200; img_offs = 25'h10;
    push_rd(1'b0, 25'h210, 3, 1'b0);
    img_req = 1'b1;
    wait_acks(1, "post_rst_tmo");
    repeat (6) @(negedge clk_sys);

    check_val("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    check_val("ack_q_empty", 32'(ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timed out");
  end
endmodule
